// File: rtl/fibo_engine.sv
// ---------------------------------------------------------------------------
// fibo_engine
//
// Self-sequencing Fibonacci engine. It accepts a term index n through a
// start/busy handshake and iterates internally. It returns F(n) mod 2^WIDTH
// together with an overflow flag and a zero flag. Every intermediate term
// F(0)..F(n) is streamed on term_data/term_valid while the engine runs, and
// the final term is emitted in the same cycle as done.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   rst        - asynchronous, active-high reset
//   start      - request, sampled only while busy is low
//   n          - term index, captured on the accepting edge
//   busy       - high from the accepting edge until the completing edge
//   done       - one-cycle pulse when result becomes valid
//   result     - F(n) mod 2^WIDTH, held until the next done
//   ovf        - true F(n) >= 2^WIDTH, updated with result
//   zero_flag  - result == 0, updated with result
//   term_valid - one-cycle strobe per emitted term
//   term_data  - emitted term F(i) mod 2^WIDTH
// ---------------------------------------------------------------------------
module fibo_engine #(
    parameter int WIDTH = 8,
    parameter int N_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero_flag,
    output logic             term_valid,
    output logic [WIDTH-1:0] term_data
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               oa_q, ob_q;
    logic [N_W-1:0]     k_q;
    logic               busy_q, done_q, ovf_q, zero_q, term_valid_q;
    logic [WIDTH-1:0]   result_q, term_data_q;

    // One bit wider than a term so the carry-out is visible.
    logic [WIDTH:0]     sum_d;

    always_comb begin
        sum_d = {1'b0, a_q} + {1'b0, b_q};
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the values from before the edge; with blocking assignments the
    // a <- b, b <- a+b swap would read the freshly written a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            oa_q         <= 1'b0;
            ob_q         <= 1'b0;
            k_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
            term_valid_q <= 1'b0;
            term_data_q  <= '0;
        end else begin
            // Strobes are single-cycle: cleared unless re-asserted below.
            done_q       <= 1'b0;
            term_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= '0;
                        b_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
                        oa_q    <= 1'b0;
                        ob_q    <= 1'b0;
                        k_q     <= n;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (k_q != '0) begin
                        a_q          <= b_q;
                        oa_q         <= ob_q;
                        b_q          <= sum_d[WIDTH-1:0];
                        // Overflow is sticky along the sequence: once a term
                        // has wrapped, every later term has wrapped too.
                        ob_q         <= sum_d[WIDTH] | oa_q | ob_q;
                        k_q          <= k_q - 1'b1;
                        term_data_q  <= a_q;
                        term_valid_q <= 1'b1;
                    end else begin
                        // Only a's shadow bit is reported; a wrap that went
                        // solely into b on the final iteration is ignored.
                        result_q     <= a_q;
                        ovf_q        <= oa_q;
                        zero_q       <= (a_q == '0);
                        done_q       <= 1'b1;
                        term_data_q  <= a_q;
                        term_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign ovf        = ovf_q;
    assign zero_flag  = zero_q;
    assign term_valid = term_valid_q;
    assign term_data  = term_data_q;

endmodule

// File: tb/tb_fibo_engine.sv
// ---------------------------------------------------------------------------
// tb_fibo_engine
//
// Directed self-checking bench for fibo_engine (WIDTH=8, N_W=5). Inputs are
// driven on the falling edge, and outputs are sampled on the falling edge
// after each rising edge. Final results are hand-computed constants. The
// term stream is compared against a small running Fibonacci model.
// ---------------------------------------------------------------------------
module tb_fibo_engine;

    localparam int WIDTH = 8;
    localparam int N_W   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N_W-1:0]   n;
    logic             busy, done, ovf, zero_flag, term_valid;
    logic [WIDTH-1:0] result, term_data;

    int n_cmp = 0;
    int n_bad = 0;

    fibo_engine #(.WIDTH(WIDTH), .N_W(N_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n          (n),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .ovf        (ovf),
        .zero_flag  (zero_flag),
        .term_valid (term_valid),
        .term_data  (term_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".done"},       32'(done),       32'd0);
        check({tag, ".result"},     32'(result),     32'd0);
        check({tag, ".ovf"},        32'(ovf),        32'd0);
        check({tag, ".zero"},       32'(zero_flag),  32'd0);
        check({tag, ".tvalid"},     32'(term_valid), 32'd0);
        check({tag, ".tdata"},      32'(term_data),  32'd0);
    endtask

    // Runs one computation. Called just after a falling edge. glitch_at
    // pulses start with n=20 after that sample index; hold keeps start=1,
    // n=3 throughout so the next run is accepted straight after done.
    task automatic do_run(input int nn, input logic [7:0] exp_res, input logic exp_ovf,
                          input logic exp_zero, input int glitch_at, input bit hold);
        logic [7:0] fa, fb, ft;
        string      tg;
        fa = 8'd0;
        fb = 8'd1;
        start = 1'b1;
        n     = N_W'(nn);
        for (int i = 0; i <= nn + 1; i++) begin
            @(negedge clk);
            tg = $sformatf("n%0d.c%0d", nn, i);
            if (i == 0) begin
                check({tg, ".busy"},   32'(busy),       32'd1);
                check({tg, ".tvalid"}, 32'(term_valid), 32'd0);
                check({tg, ".done"},   32'(done),       32'd0);
            end else begin
                check({tg, ".tvalid"}, 32'(term_valid), 32'd1);
                check({tg, ".tdata"},  32'(term_data),  32'(fa));
                check({tg, ".done"},   32'(done),       32'(i == nn + 1));
                check({tg, ".busy"},   32'(busy),       32'(i != nn + 1));
                ft = fa + fb;
                fa = fb;
                fb = ft;
            end
            if (hold) begin
                start = 1'b1;
                n     = 5'd3;
            end else if (i == glitch_at) begin
                start = 1'b1;
                n     = 5'd20;
            end else begin
                start = 1'b0;
                n     = 5'd31;
            end
        end
        check($sformatf("n%0d.result", nn), 32'(result),    32'(exp_res));
        check($sformatf("n%0d.ovf", nn),    32'(ovf),       32'(exp_ovf));
        check($sformatf("n%0d.zero", nn),   32'(zero_flag), 32'(exp_zero));
    endtask

    // One idle cycle after done: strobes low, result held.
    task automatic check_idle(input string tag, input logic [7:0] exp_res);
        @(negedge clk);
        check({tag, ".done"},   32'(done),       32'd0);
        check({tag, ".tvalid"}, 32'(term_valid), 32'd0);
        check({tag, ".busy"},   32'(busy),       32'd0);
        check({tag, ".held"},   32'(result),     32'(exp_res));
    endtask

    initial begin
        int saw_done;
        rst   = 1'b1;
        start = 1'b0;
        n     = '0;
        #1;
        check_all_zero("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("idle");
        end

        // Basic term and back-to-back-free idle check.
        do_run(10, 8'd55, 1'b0, 1'b0, -1, 1'b0);
        check_idle("n10.after", 8'd55);

        // Asynchronous reset between edges clears everything immediately.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("post_rst");
        end

        // Edge indices.
        do_run(0, 8'd0, 1'b0, 1'b1, -1, 1'b0);
        do_run(1, 8'd1, 1'b0, 1'b0, -1, 1'b0);

        // Overflow boundary: F(13)=233, F(14)=377->121, F(31)=1346269->221.
        do_run(13, 8'd233, 1'b0, 1'b0, -1, 1'b0);
        do_run(14, 8'd121, 1'b1, 1'b0, -1, 1'b0);
        do_run(31, 8'd221, 1'b1, 1'b0, -1, 1'b0);
        check_idle("n31.after", 8'd221);

        // start with n=20 mid-run is ignored.
        do_run(5, 8'd5, 1'b0, 1'b0, 2, 1'b0);
        check_idle("glitch.after", 8'd5);

        // start held through done: n=4 (F=3) then n=3 (F=2) with no gap.
        do_run(4, 8'd3, 1'b0, 1'b0, -1, 1'b1);
        do_run(3, 8'd2, 1'b0, 1'b0, -1, 1'b0);
        check_idle("b2b.after", 8'd2);

        // Reset during cycle 4 of an n=12 run discards it.
        start = 1'b1;
        n     = 5'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("mid_rst.no_done", 32'(saw_done), 32'd0);
        check("mid_rst.result",  32'(result),   32'd0);
        do_run(6, 8'd8, 1'b0, 1'b0, -1, 1'b0);
        check_idle("n6.after", 8'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
